// File: rtl/vga_hex_dump_pkg.sv
// Shared constants for the hex-dump overlay: colour codes,
// visible width, fetch column and the row-fetch FSM encoding.
package vga_hex_dump_pkg;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] FETCH_COL = H_VISIBLE;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/vga_row_fetch.sv
// Row fetch engine: reads NBYTES bytes of one row into a line
// buffer during horizontal blanking; data lags rd by one cycle.
module vga_row_fetch
  import vga_hex_dump_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter logic [7:0]  BASE   = 8'h00
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [2:0]             row_i,
  input  logic [7:0]             din_i,
  output logic [7:0]             addr_o,
  output logic                   rd_o,
  output logic                   busy_o,
  output logic [NBYTES-1:0][7:0] buf_o
);

  localparam logic [3:0] LAST = 4'(NBYTES - 1);

  fetch_state_e state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] row_base;
  logic [NBYTES-1:0][7:0] buf_q;
  logic       wr;
  logic [3:0] widx;

  assign row_base = BASE + 8'(32'(row_i) * NBYTES);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FETCH;
          k_d     = '0;
          addr_d  = row_base;
        end
      end
      FETCH: begin
        if (k_q == LAST) begin
          state_d = DRAIN;
        end else begin
          k_d    = k_q + 4'd1;
          addr_d = addr_q + 8'd1;
        end
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
    end
  end

  // The byte read in cycle k lands in cycle k+1, hence the k-1 slot.
  assign wr   = ((state_q == FETCH) && (k_q != 4'd0))
              || (state_q == DRAIN);
  assign widx = (state_q == DRAIN) ? LAST : (k_q - 4'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
    end else begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (wr && (widx == 4'(i))) begin
          buf_q[i] <= din_i;
        end
      end
    end
  end

  assign addr_o = addr_q;
  assign rd_o   = (state_q == FETCH);
  assign busy_o = (state_q != IDLE);
  assign buf_o  = buf_q;

endmodule

// File: rtl/vga_hex_dump.sv
// Hex-dump overlay: window decode, blink counter and registered
// pixel outputs around the row fetch engine.
module vga_hex_dump
  import vga_hex_dump_pkg::*;
#(
  parameter logic [9:0]  LINE       = 10'd0,
  parameter logic [9:0]  COL        = 10'd0,
  parameter int unsigned ZOOM       = 0,
  parameter logic [2:0]  PCOLOR     = WHITE,
  parameter logic [2:0]  HCOLOR     = RED,
  parameter int unsigned NBYTES     = 4,
  parameter int unsigned NROWS      = 1,
  parameter logic [7:0]  BASE       = 8'h00,
  parameter int unsigned BLINK_LOG2 = 4
) (
  input  logic       px_clk,
  input  logic       resetn,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       en,
  input  logic       freeze,
  input  logic       hl_en,
  input  logic [3:0] hl_idx,
  output logic [7:0] addr,
  output logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [2:0] color,
  output logic [1:0] zoom,
  output logic       h2a,
  output logic       busy
);

  localparam int         SH    = 3 + int'(ZOOM);
  localparam logic [9:0] CMASK = 10'((8 << ZOOM) - 1);
  localparam int         FW    = int'(BLINK_LOG2) + 1;

  logic [9:0] y1, ry, cx, cy;
  logic       start, act, hl;
  logic [7:0] byte_sel;
  logic [3:0] nib;
  logic [NBYTES-1:0][7:0] rbuf;
  logic [FW-1:0] fcnt_q;
  logic [7:0] dout_q, dout_d;
  logic [2:0] color_q, color_d;
  logic [1:0] zoom_q, zoom_d;
  logic       h2a_q, h2a_d;

  // Fetch on the last scan line above a row, once the line is drawn.
  assign y1    = y + 10'd1;
  assign ry    = (y1 >> SH) - LINE;
  assign start = (x == FETCH_COL) && en && !freeze && !busy
              && ((y1 & CMASK) == 10'd0)
              && (ry < 10'(NROWS));

  vga_row_fetch #(
    .NBYTES (NBYTES),
    .BASE   (BASE)
  ) u_fetch (
    .clk_i   (px_clk),
    .rst_ni  (resetn),
    .start_i (start),
    .row_i   (ry[2:0]),
    .din_i   (din),
    .addr_o  (addr),
    .rd_o    (rd),
    .busy_o  (busy),
    .buf_o   (rbuf)
  );

  assign cx  = (x >> SH) - COL;
  assign cy  = (y >> SH) - LINE;
  assign act = en && (cx < 10'(2 * NBYTES)) && (cy < 10'(NROWS));
  assign hl  = hl_en && (cx[4:1] == hl_idx) && fcnt_q[FW-1];

  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (cx[4:1] == 4'(i)) byte_sel = rbuf[i];
    end
  end

  assign nib = cx[0] ? byte_sel[3:0] : byte_sel[7:4];

  always_comb begin
    dout_d  = '0;
    color_d = BLACK;
    zoom_d  = '0;
    h2a_d   = 1'b0;
    if (act) begin
      dout_d  = {4'h0, nib};
      color_d = hl ? HCOLOR : PCOLOR;
      zoom_d  = 2'(ZOOM);
      h2a_d   = 1'b1;
    end
  end

  always_ff @(posedge px_clk or negedge resetn) begin
    if (!resetn) begin
      fcnt_q  <= '0;
      dout_q  <= '0;
      color_q <= BLACK;
      zoom_q  <= '0;
      h2a_q   <= 1'b0;
    end else begin
      if ((x == 10'd0) && (y == 10'd0)) fcnt_q <= fcnt_q + FW'(1);
      dout_q  <= dout_d;
      color_q <= color_d;
      zoom_q  <= zoom_d;
      h2a_q   <= h2a_d;
    end
  end

  assign dout  = dout_q;
  assign color = color_q;
  assign zoom  = zoom_q;
  assign h2a   = h2a_q;

endmodule

// File: doc/vga_hex_dump.md
VGA_HEX_DUMP -- requirements
Module: vga_hex_dump

Interface
REQ-001 SHALL have parameter LINE, default 10'd0: top row of the window, in character cells.
REQ-002 SHALL have parameter COL, default 10'd0: left column of the window, in character cells.
REQ-003 SHALL have parameter ZOOM, default 0 (range 0..2): cell size is 8<<ZOOM pixels.
REQ-004 SHALL have parameter PCOLOR, default `WHITE: normal digit colour.
REQ-005 SHALL have parameter HCOLOR, default `RED: highlight colour.
REQ-006 SHALL have parameter NBYTES, default 4 (range 1..16): bytes per row; window width is 2*NBYTES cells.
REQ-007 SHALL have parameter NROWS, default 1 (range 1..8): rows in the window.
REQ-008 SHALL have parameter BASE, default 8'h00: memory address of row 0, byte 0.
REQ-009 SHALL have parameter BLINK_LOG2, default 4: the highlight toggles every 2^BLINK_LOG2 frames.
REQ-010 px_clk  in  1  pixel clock; the block's only clock.
REQ-011 resetn  in  1  asynchronous active-low reset.
REQ-012 x, y  in  10 each  current screen pixel position.
REQ-013 en  in  1  enables display and fetch.
REQ-014 freeze  in  1  when high, suppresses fetches and holds the snapshot.
REQ-015 hl_en, hl_idx  in  1, 4  enable and byte column index of the highlighted byte.
REQ-016 addr, rd  out  8, 1  memory read address and read strobe; the memory returns din one cycle after rd.
REQ-017 din  in  8  memory read data.
REQ-018 dout  out  8  {4'h0, nibble} to render.
REQ-019 color, zoom, h2a  out  3, 2, 1  digit colour, zoom level, and hex-to-ASCII translation request.
REQ-020 busy  out  1  high while a fetch is in progress.

Function
REQ-021 Row fetch trigger: when x==640, en=1, freeze=0, the FSM is IDLE, ((y+1) mod (8<<ZOOM))==0, and r=((y+1)>>(3+ZOOM))-LINE lies in 0..NROWS-1, the block SHALL start fetching row r.
REQ-022 FSM SHALL use three states: IDLE -> FETCH (NBYTES cycles) -> DRAIN (1 cycle) -> IDLE; busy=1 in FETCH and DRAIN.
REQ-023 In FETCH cycle k, the block SHALL drive rd=1 and addr=(BASE+r*NBYTES+k) mod 256, with 8-bit wrap.
REQ-024 The block SHALL write din to buf[k-1] in FETCH cycle k (k>=1) and to buf[NBYTES-1] in DRAIN.
REQ-025 Outside FETCH, rd SHALL be 0 and addr SHALL hold its last value.
REQ-026 Triggers arriving while busy=1 SHALL be ignored.
REQ-027 A freeze asserted mid-fetch SHALL let the current fetch complete.
REQ-028 Active cell: cx=(x>>(3+ZOOM))-COL in 0..2*NBYTES-1 and cy=(y>>(3+ZOOM))-LINE in 0..NROWS-1 with en=1; comparisons SHALL be unsigned.
REQ-029 For an active cell, the byte is cx>>1 and the nibble is buf[cx>>1][7:4] when cx[0]=0, else [3:0].
REQ-030 Outputs SHALL be registered with a latency of exactly 1 px_clk from x/y.
REQ-031 Active: dout={4'h0,nibble}, zoom=ZOOM, h2a=1, color=PCOLOR.
REQ-032 Active and highlighted: when hl_en=1, (cx>>1)==hl_idx and blink=1, color=HCOLOR.
REQ-033 Inactive: dout=0, color=`BLACK, zoom=0, h2a=0.
REQ-034 hl_idx>=NBYTES SHALL highlight nothing.
REQ-035 Blink: a BLINK_LOG2+1-bit frame counter SHALL increment when x==0 and y==0; blink is its MSB.

Reset
REQ-036 While resetn=0, the block SHALL hold: state=IDLE, busy=0, rd=0, addr=0, buf all 0, frame counter 0, dout=0, color=`BLACK, zoom=0, h2a=0.
REQ-037 A reset mid-fetch SHALL abort the fetch; no further rd after deassertion until the next trigger.

Structure
REQ-038 Colour codes, H_VISIBLE=640, and the fetch column SHALL live in shared const.vh.
REQ-039 The FSM and buffer SHALL form sub-module vga_row_fetch; the top level SHALL contain the window decode, blink, and output register.

Verification
REQ-040 Scenario: NBYTES=4, BASE=8'h10, memory[i]=i; trigger for row 0 -> rd high for 4 cycles, addr 10,11,12,13, then busy low; the displayed row reads digits 1,0,1,1,1,2,1,3.
REQ-041 Scenario: BASE=8'hFE, NBYTES=4 -> addr FE,FF,00,01.
REQ-042 Scenario: capture 12345678, set freeze=1, change memory -> display stays 12345678 over 3 frames; set freeze=0 -> new value appears on the next row fetch.
REQ-043 Scenario: pulse resetn low during FETCH cycle 2 -> rd=0 immediately, busy=0, buf=0, all digits render 0.
REQ-044 Scenario: hl_en=1, hl_idx=1, BLINK_LOG2=1 -> cells cx=2,3 alternate HCOLOR/PCOLOR every 2 frames; hl_idx=5 -> no HCOLOR.
REQ-045 Scenario: x at the cell left of COL and at cx=2*NBYTES -> h2a=0 and color=BLACK one cycle later; x at cx=0 -> h2a=1.
